// File: rtl/tone_pkg.sv
// Shared types, constants and helpers for the multi-channel tone generator.
package tone_pkg;

    typedef enum logic [1:0] {
        MODE_OFF    = 2'b00,
        MODE_SQUARE = 2'b01,
        MODE_PULSE  = 2'b10,
        MODE_NOISE  = 2'b11
    } mode_t;

    typedef enum logic {
        PH_LOW  = 1'b0,
        PH_HIGH = 1'b1
    } phase_t;

    localparam int unsigned       LFSR_W     = 15;
    localparam logic [LFSR_W-1:0] LFSR_SEED  = 15'h7FFF;
    localparam int unsigned       LFSR_TAP_A = 14;
    localparam int unsigned       LFSR_TAP_B = 13;

    // Wide working width for the clamp; mixer widths must not exceed it.
    localparam int unsigned SAT_W = 64;

    // Clamp a signed value into the signed range of a w-bit result.
    function automatic logic signed [SAT_W-1:0] saturate(
        input logic signed [SAT_W-1:0] x,
        input int unsigned             w
    );
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (x > hi) begin
            return hi;
        end
        if (x < lo) begin
            return lo;
        end
        return x;
    endfunction

endpackage

// File: rtl/tone_channel.sv
// One tone channel: segment counter, phase, shadowed half-period and noise LFSR.
module tone_channel
    import tone_pkg::*;
#(
    parameter int unsigned PERIOD_W = 20,
    parameter int unsigned AMP_W    = 24,
    parameter int unsigned OUT_W    = 32
) (
    input  logic                       CLOCK_50,
    input  logic                       reset,
    input  logic [PERIOD_W-1:0]        half_period,
    input  logic [AMP_W-1:0]           amplitude,
    input  mode_t                      mode,
    input  logic                       sync,
    output logic signed [OUT_W-1:0]    v_c
);

    localparam int unsigned CNT_W = PERIOD_W + 2;

    logic [CNT_W-1:0]    count_q, count_d;
    phase_t              phase_q, phase_d;
    logic [PERIOD_W-1:0] ha_q, ha_d;
    logic [LFSR_W-1:0]   lfsr_q, lfsr_d;

    logic [CNT_W-1:0]    full_len;
    logic [CNT_W-1:0]    high_len;
    logic [CNT_W-1:0]    seg_len;
    logic                seg_end;
    logic signed [OUT_W-1:0] amp_s;

    // Length of the current segment from the active half-period and mode.
    always_comb begin
        full_len = CNT_W'(ha_q) + CNT_W'(1);
        high_len = full_len >> 1;
        if (high_len == '0) begin
            high_len = CNT_W'(1);
        end
        seg_len = full_len;
        if (mode == MODE_PULSE) begin
            seg_len = (phase_q == PH_HIGH) ? high_len : (full_len << 1) - high_len;
        end
        seg_end = (count_q >= seg_len - CNT_W'(1));
    end

    // Next state: off/sync restart, otherwise count and flip phase at segment end.
    always_comb begin
        count_d = count_q + CNT_W'(1);
        phase_d = phase_q;
        ha_d    = ha_q;
        lfsr_d  = lfsr_q;
        if (sync || mode == MODE_OFF) begin
            count_d = '0;
            phase_d = PH_LOW;
            ha_d    = half_period;
        end else if (seg_end) begin
            count_d = '0;
            phase_d = (phase_q == PH_HIGH) ? PH_LOW : PH_HIGH;
            if (phase_q == PH_HIGH) begin
                ha_d = half_period;
            end
            if (mode == MODE_NOISE) begin
                lfsr_d = {lfsr_q[LFSR_W-2:0], lfsr_q[LFSR_TAP_A] ^ lfsr_q[LFSR_TAP_B]};
            end
        end
    end

    // Channel state register.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            count_q <= '0;
            phase_q <= PH_LOW;
            ha_q    <= '0;
            lfsr_q  <= LFSR_SEED;
        end else begin
            count_q <= count_d;
            phase_q <= phase_d;
            ha_q    <= ha_d;
            lfsr_q  <= lfsr_d;
        end
    end

    // Signed contribution; amplitude is zero-extended before negation.
    always_comb begin
        amp_s = $signed(OUT_W'(amplitude));
        v_c   = '0;
        case (mode)
            MODE_OFF:   v_c = '0;
            MODE_NOISE: v_c = lfsr_q[0] ? amp_s : -amp_s;
            default:    v_c = (phase_q == PH_HIGH) ? amp_s : -amp_s;
        endcase
    end

endmodule

// File: rtl/tone_gen_multi.sv
// Multi-channel tone generator with a saturating, registered mixer.
module tone_gen_multi
    import tone_pkg::*;
#(
    parameter int unsigned NUM_CH   = 4,
    parameter int unsigned PERIOD_W = 20,
    parameter int unsigned AMP_W    = 24,
    parameter int unsigned OUT_W    = 32
) (
    input  logic                         CLOCK_50,
    input  logic                         reset,
    input  logic [NUM_CH*PERIOD_W-1:0]   half_period,
    input  logic [NUM_CH*AMP_W-1:0]      amplitude,
    input  logic [NUM_CH*2-1:0]          mode,
    input  logic                         sync,
    output logic signed [OUT_W-1:0]      out
);

    localparam int unsigned SUM_W = OUT_W + $clog2(NUM_CH);

    logic signed [OUT_W-1:0] v_c [NUM_CH];
    logic signed [SUM_W-1:0] sum_c;
    logic signed [OUT_W-1:0] mix_c;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        tone_channel #(
            .PERIOD_W (PERIOD_W),
            .AMP_W    (AMP_W),
            .OUT_W    (OUT_W)
        ) u_ch (
            .CLOCK_50    (CLOCK_50),
            .reset       (reset),
            .half_period (half_period[i*PERIOD_W +: PERIOD_W]),
            .amplitude   (amplitude[i*AMP_W +: AMP_W]),
            .mode        (mode_t'(mode[i*2 +: 2])),
            .sync        (sync),
            .v_c         (v_c[i])
        );
    end

    // Sum at widened precision, then clamp to the output range.
    always_comb begin
        sum_c = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            sum_c = sum_c + SUM_W'(v_c[i]);
        end
        mix_c = OUT_W'(saturate(SAT_W'(sum_c), OUT_W));
    end

    // Output sample register.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            out <= '0;
        end else begin
            out <= mix_c;
        end
    end

endmodule
